// File: rtl/backscatter_burst_scheduler.sv
// Backscatter burst sequencer: after an accepted packet detect, waits DELAY_CYCLES and then
// on-off-keys the shift-clock trigger with BITS_PER_BURST tag bits, each held for BIT_CYCLES.
//   state  | meaning
//   IDLE   | waiting for packet_detect
//   DELAY  | fixed delay before the first bit slot
//   ACTIVE | bit slots in progress, trigger carries the current bit
//   GUARD  | holdoff after a burst before re-arming
module backscatter_burst_scheduler #(
    parameter int DELAY_CYCLES   = 640,
    parameter int BIT_CYCLES     = 640,
    parameter int BITS_PER_BURST = 32,
    parameter int HOLDOFF_CYCLES = 1280,
    parameter int CNT_W          = 16
) (
    input  logic clock_in,
    input  logic reset,
    input  logic packet_detect,
    input  logic abort,
    input  logic bit_valid,
    input  logic bit_data,
    output logic bit_ready,
    output logic trigger_signal,
    output logic busy,
    output logic burst_done,
    output logic underrun
);
    typedef enum logic [1:0] {IDLE, DELAY, ACTIVE, GUARD} state_t;

    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BITS_PER_BURST - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] slot_q, slot_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             trig_q, trig_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             under_q, under_d;
    logic             delay_end, slot_end, last_bit;

    assign delay_end = (state_q == DELAY) && (cnt_q == DELAY_LAST);
    assign slot_end  = (state_q == ACTIVE) && (slot_q == BIT_LAST);
    assign last_bit  = (idx_q == BURST_LAST);
    // The next bit is fetched on the edge that opens its slot, so the trigger only moves on slot boundaries.
    assign bit_ready = !abort && (delay_end || (slot_end && !last_bit));

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            slot_q  <= '0;
            idx_q   <= '0;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            under_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            idx_q   <= idx_d;
            trig_q  <= trig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            under_q <= under_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        idx_d   = idx_q;
        trig_d  = trig_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        under_d = under_q;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            slot_d  = '0;
            idx_d   = '0;
            trig_d  = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (packet_detect) begin
                        state_d = DELAY;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        under_d = 1'b0;
                    end
                end
                DELAY: begin
                    if (delay_end) begin
                        state_d = ACTIVE;
                        cnt_d   = '0;
                        slot_d  = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                ACTIVE: begin
                    if (slot_end) begin
                        slot_d = '0;
                        if (last_bit) begin
                            state_d = GUARD;
                            cnt_d   = '0;
                            idx_d   = '0;
                            trig_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + ONE;
                        end
                    end else begin
                        slot_d = slot_q + ONE;
                    end
                end
                GUARD: begin
                    trig_d = 1'b0;
                    if (cnt_q == HOLD_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (bit_ready) begin
                trig_d = bit_valid & bit_data;
                if (!bit_valid) under_d = 1'b1;
            end
        end
    end

    assign trigger_signal = trig_q;
    assign busy           = busy_q;
    assign burst_done     = done_q;
    assign underrun       = under_q;
endmodule

// File: tb/tb_backscatter_burst_scheduler.sv
// Scoreboard bench: each accepted detect pushes the expected slot boundaries, trigger levels,
// done pulse and busy window; the per-cycle monitor pops and compares them.
module tb_backscatter_burst_scheduler;
    localparam int DLY  = 4;
    localparam int BITC = 8;
    localparam int NB   = 4;
    localparam int HOLD = 6;

    logic clock_in = 1'b0;
    logic reset = 1'b0, packet_detect = 1'b0, abort = 1'b0, bit_valid = 1'b0, bit_data = 1'b0;
    logic bit_ready, trigger_signal, busy, burst_done, underrun;

    always #5 clock_in = ~clock_in;

    backscatter_burst_scheduler #(
        .DELAY_CYCLES(DLY), .BIT_CYCLES(BITC), .BITS_PER_BURST(NB),
        .HOLDOFF_CYCLES(HOLD), .CNT_W(16)
    ) dut (
        .clock_in(clock_in), .reset(reset), .packet_detect(packet_detect), .abort(abort),
        .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready),
        .trigger_signal(trigger_signal), .busy(busy), .burst_done(burst_done), .underrun(underrun)
    );

    typedef struct {int e; logic trig;} slot_t;
    typedef struct {logic v; logic d;} bit_t;
    typedef struct {int e; logic v;} ev_t;

    slot_t sb_q[$];
    bit_t  src_q[$];
    ev_t   busy_q[$];
    int    done_q[$];
    int    edge_n = 0, n_checks = 0, n_errors = 0, consumed = 0, c0 = 0;
    logic  trig_exp = 1'b0, busy_exp = 1'b0, ur_exp = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, edge_n);
        end
    endtask

    task automatic offer(input logic v, input logic d);
        bit_t b;
        b.v = v;
        b.d = d;
        src_q.push_back(b);
    endtask

    task automatic flush_model();
        sb_q.delete();
        done_q.delete();
        busy_q.delete();
        trig_exp = 1'b0;
        busy_exp = 1'b0;
    endtask

    // One clock: drive the bit source, sample bit_ready, take the edge, then compare outputs.
    task automatic tick();
        logic rdy, val, pd, ab, idle_pre, rst_pre, done_e;
        slot_t s;
        ev_t ev;
        if (src_q.size() > 0) begin
            bit_valid = src_q[0].v;
            bit_data  = src_q[0].d;
        end else begin
            bit_valid = 1'b0;
            bit_data  = 1'b0;
        end
        #1;
        rdy = bit_ready; val = bit_valid; pd = packet_detect; ab = abort;
        idle_pre = !busy_exp; rst_pre = reset;
        @(posedge clock_in);
        edge_n++;
        #1;
        if (rst_pre) begin
            if (ab) begin
                flush_model();
            end else if (pd && idle_pre) begin
                ur_exp = 1'b0;
                for (int k = 0; k < NB; k++) begin
                    s.e = edge_n + DLY + k * BITC;
                    s.trig = (k < src_q.size()) ? (src_q[k].v & src_q[k].d) : 1'b0;
                    sb_q.push_back(s);
                end
                done_q.push_back(edge_n + DLY + NB * BITC);
                ev.e = edge_n; ev.v = 1'b1; busy_q.push_back(ev);
                ev.e = edge_n + DLY + NB * BITC + HOLD; ev.v = 1'b0; busy_q.push_back(ev);
            end
        end
        while (busy_q.size() > 0 && busy_q[0].e == edge_n) begin
            busy_exp = busy_q[0].v;
            void'(busy_q.pop_front());
        end
        while (sb_q.size() > 0 && sb_q[0].e < edge_n) begin
            check("ready_missing", 0, 1);
            void'(sb_q.pop_front());
        end
        if (rdy) begin
            if (val) consumed++;
            else ur_exp = 1'b1;
            if (src_q.size() > 0) void'(src_q.pop_front());
            if (sb_q.size() == 0) begin
                check("ready_extra", 1, 0);
            end else begin
                check("ready_edge", edge_n, sb_q[0].e);
                trig_exp = sb_q[0].trig;
                void'(sb_q.pop_front());
            end
        end
        done_e = (done_q.size() > 0 && done_q[0] == edge_n);
        if (done_e) begin
            void'(done_q.pop_front());
            trig_exp = 1'b0;
        end
        check("trigger", trigger_signal, trig_exp);
        check("busy", busy, busy_exp);
        check("burst_done", burst_done, done_e);
        check("underrun", underrun, ur_exp);
        @(negedge clock_in);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        repeat (3) @(negedge clock_in);
        check("rst_trigger", trigger_signal, 0);
        check("rst_busy", busy, 0);
        check("rst_done", burst_done, 0);
        check("rst_underrun", underrun, 0);
        check("rst_ready", bit_ready, 0);
        reset = 1'b1;

        // normal burst 1,0,1,1
        offer(1, 1); offer(1, 0); offer(1, 1); offer(1, 1);
        packet_detect = 1'b1; tick(); packet_detect = 1'b0;
        run(45);

        // underrun on the second slot
        offer(1, 1); offer(0, 0); offer(1, 1); offer(1, 0);
        packet_detect = 1'b1; tick(); packet_detect = 1'b0;
        run(45);
        check("underrun_sticky", underrun, 1);

        // detect held high: back-to-back bursts, detect also clears underrun
        offer(1, 0); offer(1, 1); offer(1, 1); offer(1, 0);
        offer(1, 1); offer(1, 1); offer(1, 0); offer(1, 1);
        packet_detect = 1'b1; run(85); packet_detect = 1'b0;
        run(5);

        // abort with slot_cnt=3 of the third slot
        offer(1, 1); offer(1, 1); offer(1, 1); offer(1, 1);
        c0 = consumed;
        packet_detect = 1'b1; tick(); packet_detect = 1'b0;
        run(23);
        abort = 1'b1; tick(); abort = 1'b0;
        run(5);
        check("abort_consumed", consumed - c0, 3);
        src_q.delete();

        // async reset mid-ACTIVE with trigger high and underrun set
        offer(0, 0); offer(1, 1); offer(1, 1); offer(1, 1);
        packet_detect = 1'b1; tick(); packet_detect = 1'b0;
        run(15);
        check("pre_reset_trig", trigger_signal, 1);
        #2 reset = 1'b0;
        #1;
        check("async_trigger", trigger_signal, 0);
        check("async_busy", busy, 0);
        check("async_done", burst_done, 0);
        check("async_underrun", underrun, 0);
        flush_model();
        ur_exp = 1'b0;
        src_q.delete();
        tick();
        reset = 1'b1;
        run(3);
        offer(1, 1); offer(1, 0); offer(1, 1); offer(1, 0);
        packet_detect = 1'b1; tick(); packet_detect = 1'b0;
        run(45);

        // detects during DELAY and GUARD are ignored
        offer(1, 0); offer(1, 1); offer(1, 0); offer(1, 1);
        c0 = consumed;
        packet_detect = 1'b1; tick(); packet_detect = 1'b0;
        run(2);
        packet_detect = 1'b1; tick(); packet_detect = 1'b0;
        run(36);
        packet_detect = 1'b1; tick(); packet_detect = 1'b0;
        run(6);
        check("single_burst_bits", consumed - c0, 4);

        check("sb_left", sb_q.size(), 0);
        check("done_left", done_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/backscatter_burst_scheduler.md
Name: backscatter_burst_scheduler

Overview:
Sequences the 10 MHz shift-clock generator for one backscatter burst. Armed by an excitation-packet detect, it waits a fixed delay and then runs BITS_PER_BURST bit slots. In each slot it drives trigger_signal to on-off-key the shift clock with one tag data bit, taken from an upstream valid/ready bit source. It sits between the packet detector / tag data source and the shift-clock divider's trigger_signal input.

Parameters:
DELAY_CYCLES, 640, clock_in cycles from detect acceptance to first bit slot (must be >=1)
BIT_CYCLES, 640, clock_in cycles per bit slot (must be >=2)
BITS_PER_BURST, 32, bit slots per burst (must be >=1)
HOLDOFF_CYCLES, 1280, guard cycles after a burst before re-arming (must be >=1)
CNT_W, 16, width of cycle counters (all cycle parameters < 2^CNT_W)

Ports:
clock_in  input  1  system clock
reset  input  1  asynchronous, active-low reset
packet_detect  input  1  excitation packet detected; level sampled on each clock_in edge
abort  input  1  synchronous abort of any burst in progress
bit_valid  input  1  upstream bit available
bit_data  input  1  tag data bit (1 = shift clock on)
bit_ready  output  1  combinational; bit consumed on an edge where bit_valid && bit_ready
trigger_signal  output  1  registered enable to the shift-clock divider
busy  output  1  registered; high in every state except IDLE
burst_done  output  1  registered one-cycle pulse on normal burst completion
underrun  output  1  registered sticky flag; a slot started with no bit available

Behaviour:
- Reset: all outputs 0 except bit_ready, which is combinational and therefore 0 in IDLE. State = IDLE; all counters = 0. Reset is asynchronous, active-low; clock clock_in.
- States: IDLE, DELAY, ACTIVE, GUARD. abort has priority over every other transition in every state.
- IDLE: on an edge with packet_detect=1 and abort=0 -> DELAY. At that edge: cnt=0, busy<=1, underrun<=0.
- DELAY: cnt increments each cycle. On the edge where cnt==DELAY_CYCLES-1 -> ACTIVE, with slot_cnt=0 and bit_idx=0.
- ACTIVE: slot_cnt counts 0..BIT_CYCLES-1 and wraps; bit_idx increments on each wrap.
- bit_ready=1 only when abort=0 and one of the following holds:
  - state DELAY with cnt==DELAY_CYCLES-1;
  - state ACTIVE with slot_cnt==BIT_CYCLES-1 and bit_idx<BITS_PER_BURST-1.
- On each edge where bit_ready=1: trigger_signal <= bit_valid & bit_data. If bit_valid=0, underrun<=1 and the slot is sent as 0. The bit count still advances; there is no stall.
- Consequence: trigger_signal changes exactly on slot boundaries and holds for exactly BIT_CYCLES cycles per slot. First slot: trigger may rise at edge T+1+DELAY_CYCLES, where T is the detect edge.
- Last slot end (slot_cnt==BIT_CYCLES-1, bit_idx==BITS_PER_BURST-1):
  - trigger_signal<=0;
  - -> GUARD with cnt=0;
  - burst_done<=1 for exactly one cycle.
- GUARD: trigger_signal=0. On the edge where cnt==HOLDOFF_CYCLES-1 -> IDLE, busy<=0.
- packet_detect is ignored in DELAY, ACTIVE and GUARD; it is not queued. A detect in the same cycle as GUARD->IDLE is ignored. The next sampled edge in IDLE re-arms.
- abort=1 in any state: next edge -> IDLE; trigger_signal<=0, busy<=0, counters<=0, no burst_done. underrun keeps its value. bit_ready=0 while abort=1, so no bit is consumed.
- Reset asserted mid-burst: immediate return to reset values. trigger_signal falls asynchronously.
- underrun clears only on the next accepted packet_detect.
- Counter comparisons are equality on CNT_W-bit counters. No counter wraps past its terminal value.

Test Plan:
All scenarios use DELAY_CYCLES=4, BIT_CYCLES=8, BITS_PER_BURST=4, HOLDOFF_CYCLES=6.
1. Normal burst: detect pulse at edge T, bits 1,0,1,1 always valid.
   -> bit_ready pulses at T+4, T+12, T+20, T+28.
   -> trigger_signal high T+5..T+12, low T+13..T+20, high T+21..T+36 (inclusive cycles), 0 from T+37.
   -> burst_done single pulse in cycle T+37; busy falls after 6 GUARD cycles (low from T+43).
2. Underrun: bit_valid=0 at the 2nd bit_ready cycle.
   -> slot 2 trigger=0, underrun=1 and held through GUARD.
   -> next detect clears underrun.
3. Re-trigger: packet_detect held high throughout.
   -> bursts do not overlap; the second burst's DELAY starts the edge after IDLE is re-entered (busy low for exactly 1 cycle).
4. Abort mid-slot 3 (slot_cnt=3).
   -> next cycle trigger=0, busy=0, burst_done never pulses; bits consumed = 3.
5. Async reset asserted mid-ACTIVE with trigger high.
   -> trigger, busy, burst_done, underrun = 0 immediately; after release, a detect starts a clean burst with bit_idx=0.
6. Detect arriving during DELAY and GUARD -> ignored; exactly one burst of 4 bits, no extra bit_ready pulses.
